// File: rtl/nch_mixer_pkg.sv
// Shared word-class constants, synthetic word generators and FSM state type
// for the N-channel frame mixer.
package nch_mixer_pkg;

  // Header: top 7 bits all ones.
  localparam logic [6:0] HDR_MARK = 7'h7F;
  // Footer: top 2 bits ones and low 5 bits 01111 (and not a header).
  localparam logic [1:0] FTR_TOP  = 2'b11;
  localparam logic [4:0] FTR_LOW  = 5'b01111;

  // Widest word the generators can build; callers keep the low bits.
  localparam int MAX_W = 1024;
  typedef logic [MAX_W-1:0] wide_t;

  typedef enum logic {IDLE, STREAM} state_t;

  // All ones in the low w bits.
  function automatic wide_t ones(input int unsigned w);
    return {MAX_W{1'b1}} >> (MAX_W - w);
  endfunction

  // {8'hFE, all-ones, 8'h00} of width w.
  function automatic wide_t synth_hdr(input int unsigned w);
    return ones(w) & ~wide_t'(8'hFF) & ~(wide_t'(1) << (w - 8));
  endfunction

  // {4'b1100, all-ones, 8'hEF} of width w.
  function automatic wide_t synth_ftr(input int unsigned w);
    return ones(w) & ~(wide_t'(1) << 4) & ~(wide_t'(1) << (w - 3)) &
           ~(wide_t'(1) << (w - 4));
  endfunction

endpackage

// File: rtl/nch_frame_mixer_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester after last_grant,
// searching upward modulo N, wins.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last_grant,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx
);

  // Scan N candidates starting one past the previous winner.
  always_comb begin
    int   c;
    logic found;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    for (int i = 1; i <= N; i++) begin
      c = (int'(last_grant) + i) % N;
      if (!found && req[c]) begin
        found  = 1'b1;
        gnt[c] = 1'b1;
        idx    = $clog2(N)'(c);
      end
    end
  end

endmodule

// File: rtl/nch_frame_mixer.sv
// Merges framed words from N_CH FWFT FIFOs into one valid/ready stream, one
// whole frame at a time, repairing lost headers/footers and closing overlong
// frames.
module nch_frame_mixer
  import nch_mixer_pkg::*;
#(
  parameter int N_CH            = 4,
  parameter int DATA_WIDTH      = 64,
  parameter int MAX_FRAME_WORDS = 256
) (
  input  logic                       CLK,
  input  logic                       RESETN,
  input  logic [N_CH*DATA_WIDTH-1:0] CH_DIN,
  input  logic [N_CH-1:0]            CH_READ_REQUEST,
  output logic [N_CH-1:0]            CH_RE,
  output logic [DATA_WIDTH-1:0]      DOUT,
  output logic                       oVALID,
  input  logic                       iREADY,
  output logic [$clog2(N_CH)-1:0]    GRANT_CH,
  output logic                       BUSY,
  output logic                       ERR_HDR_LOST,
  output logic                       ERR_FTR_LOST,
  output logic                       ERR_TIMEOUT
);

  localparam int W  = DATA_WIDTH;
  localparam int GW = $clog2(N_CH);
  localparam int CW = $clog2(MAX_FRAME_WORDS + 1);

  localparam wide_t          SYN_HDR_WIDE = synth_hdr(W);
  localparam wide_t          SYN_FTR_WIDE = synth_ftr(W);
  localparam logic [W-1:0]   SYN_HDR      = SYN_HDR_WIDE[W-1:0];
  localparam logic [W-1:0]   SYN_FTR      = SYN_FTR_WIDE[W-1:0];
  localparam logic [W-1:0]   RST_WORD     = {8'h00, {(W-8){1'b1}}};
  localparam logic [CW-1:0]  LAST_CNT     = CW'(MAX_FRAME_WORDS - 1);

  state_t          state, state_nxt;
  logic [GW-1:0]   grant, last_grant, arb_idx;
  logic [N_CH-1:0] arb_gnt;
  logic [CW-1:0]   wcnt;
  logic [W-1:0]    dout, head, load_word;
  logic            ovalid, any_req, out_free, is_hdr, is_ftr;
  logic            load, pop, e_hdr, e_ftr, e_to;
  logic            err_hdr, err_ftr, err_to;

  rr_arbiter #(.N(N_CH)) u_arb (
    .req        (CH_READ_REQUEST),
    .last_grant (last_grant),
    .gnt        (arb_gnt),
    .idx        (arb_idx)
  );

  assign any_req  = |arb_gnt;
  assign head     = CH_DIN[int'(grant)*W +: W];
  assign is_hdr   = (head[W-1 -: 7] == HDR_MARK);
  assign is_ftr   = !is_hdr && (head[W-1 -: 2] == FTR_TOP) && (head[4:0] == FTR_LOW);
  assign out_free = !ovalid || iREADY;

  // Next state, word selection (synthetic header/footer or FIFO head) and pop strobe.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    load_word = head;
    pop       = 1'b0;
    e_hdr     = 1'b0;
    e_ftr     = 1'b0;
    e_to      = 1'b0;
    CH_RE     = '0;
    case (state)
      IDLE: if (any_req) state_nxt = STREAM;
      STREAM: begin
        if (out_free) begin
          load = 1'b1;
          if (wcnt == '0 && !is_hdr) begin
            load_word = SYN_HDR;
            e_hdr     = 1'b1;
          end else if (wcnt != '0 && is_hdr) begin
            // The header stays at the FIFO head to open the next frame.
            load_word = SYN_FTR;
            e_ftr     = 1'b1;
            state_nxt = IDLE;
          end else if (wcnt == LAST_CNT && !is_ftr) begin
            load_word = SYN_FTR;
            e_to      = 1'b1;
            state_nxt = IDLE;
          end else begin
            pop = 1'b1;
            if (is_ftr) state_nxt = IDLE;
          end
        end
        if (pop) CH_RE[grant] = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, grant bookkeeping, word counter and the registered output word.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= GW'(N_CH - 1);
      wcnt       <= '0;
      dout       <= RST_WORD;
      ovalid     <= 1'b0;
      err_hdr    <= 1'b0;
      err_ftr    <= 1'b0;
      err_to     <= 1'b0;
    end else begin
      state   <= state_nxt;
      err_hdr <= e_hdr;
      err_ftr <= e_ftr;
      err_to  <= e_to;
      if (state == IDLE) begin
        if (ovalid && iREADY) ovalid <= 1'b0;
        if (any_req) begin
          grant      <= arb_idx;
          last_grant <= arb_idx;
          wcnt       <= '0;
        end
      end else if (load) begin
        dout   <= load_word;
        ovalid <= 1'b1;
        wcnt   <= wcnt + CW'(1);
      end
    end
  end

  assign DOUT         = dout;
  assign oVALID       = ovalid;
  assign GRANT_CH     = grant;
  assign BUSY         = (state == STREAM);
  assign ERR_HDR_LOST = err_hdr;
  assign ERR_FTR_LOST = err_ftr;
  assign ERR_TIMEOUT  = err_to;

endmodule

// File: tb/tb_nch_frame_mixer.sv
// Scoreboard bench for nch_frame_mixer (4 channels, 64-bit words, 4-word max frame).
module tb_nch_frame_mixer;

  localparam logic [63:0] SH  = 64'hFEFF_FFFF_FFFF_FF00;
  localparam logic [63:0] SF  = 64'hCFFF_FFFF_FFFF_FFEF;
  localparam logic [63:0] RSW = 64'h00FF_FFFF_FFFF_FFFF;

  logic         CLK = 1'b0;
  logic         RESETN;
  logic [255:0] ch_din;
  logic [3:0]   ch_req, ch_re;
  logic [63:0]  dout;
  logic         ovalid, iready, busy, e_hdr, e_ftr, e_to;
  logic [1:0]   grant;

  typedef struct packed { logic [63:0] w; int gap; } exp_t;
  exp_t exp_q[$];

  logic [63:0] mem [4][32];
  int wp [4];
  int rp [4];
  int re_cnt [4];
  int n_cmp = 0, n_bad = 0;
  int cnt_hdr = 0, cnt_ftr = 0, cnt_to = 0;
  int cyc = 0, last_xfer = 0;
  bit rnd = 1'b0;

  nch_frame_mixer #(.N_CH(4), .DATA_WIDTH(64), .MAX_FRAME_WORDS(4)) dut (
    .CLK(CLK), .RESETN(RESETN), .CH_DIN(ch_din), .CH_READ_REQUEST(ch_req),
    .CH_RE(ch_re), .DOUT(dout), .oVALID(ovalid), .iREADY(iready),
    .GRANT_CH(grant), .BUSY(busy), .ERR_HDR_LOST(e_hdr),
    .ERR_FTR_LOST(e_ftr), .ERR_TIMEOUT(e_to)
  );

  always #5 CLK = ~CLK;

  // FWFT FIFO heads and request flags.
  always_comb begin
    ch_din = '0;
    ch_req = '0;
    for (int k = 0; k < 4; k++) begin
      if (rp[k] < wp[k] && rp[k] < 32) begin
        ch_din[k*64 +: 64] = mem[k][rp[k]];
        ch_req[k] = 1'b1;
      end
    end
  end

  // FIFO pops.
  always @(posedge CLK) begin
    for (int k = 0; k < 4; k++)
      if (ch_re[k] && rp[k] < wp[k]) rp[k] <= rp[k] + 1;
  end

  function automatic logic [63:0] hw(input logic [7:0] t); return {8'hFE, 48'h0, t}; endfunction
  function automatic logic [63:0] fw(input logic [7:0] t); return {8'hC0, 40'h0, t, 8'h2F}; endfunction
  function automatic logic [63:0] dw(input logic [7:0] t); return {56'h0, t}; endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input int ch, input logic [63:0] w);
    mem[ch][wp[ch]] = w;
    wp[ch]++;
  endtask

  task automatic expect_w(input logic [63:0] w, input int gap);
    exp_t e;
    e.w = w;
    e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic clr_counts();
    cnt_hdr = 0; cnt_ftr = 0; cnt_to = 0;
    for (int k = 0; k < 4; k++) re_cnt[k] = 0;
  endtask

  task automatic check_errs(input string name, input int h, input int f, input int t);
    chk({name, "_hdr_lost"}, 64'(cnt_hdr), 64'(h));
    chk({name, "_ftr_lost"}, 64'(cnt_ftr), 64'(f));
    chk({name, "_timeout"},  64'(cnt_to),  64'(t));
  endtask

  task automatic check_reset_state(input string name);
    chk({name, "_ovalid"}, 64'(ovalid), 64'(0));
    chk({name, "_busy"},   64'(busy),   64'(0));
    chk({name, "_ch_re"},  64'(ch_re),  64'(0));
    chk({name, "_dout"},   dout,        RSW);
    chk({name, "_grant"},  64'(grant),  64'(0));
    chk({name, "_errs"},   64'({e_hdr, e_ftr, e_to}), 64'(0));
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge CLK);
      n++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s_drain: %0d words outstanding after %0d cycles, required 0", name, exp_q.size(), n);
      exp_q.delete();
    end
    repeat (3) @(posedge CLK);
    #1;
  endtask

  // Monitor: pops the scoreboard on every transfer and tallies pulses/pops.
  always @(negedge CLK) begin
    cyc++;
    if (RESETN === 1'b1) begin
      chk("ch_re_onehot", 64'($countones(ch_re) <= 1), 64'(1));
      if (e_hdr) cnt_hdr++;
      if (e_ftr) cnt_ftr++;
      if (e_to)  cnt_to++;
      for (int k = 0; k < 4; k++) if (ch_re[k]) re_cnt[k]++;
      if (ovalid && iready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_word: got %h required none", dout);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("dout", dout, e.w);
          if (e.gap >= 0) chk("gap", 64'(cyc - last_xfer), 64'(e.gap));
        end
        last_xfer = cyc;
      end
    end
  end

  // Random backpressure driver.
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (rnd) iready = ($urandom_range(0, 1) == 1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int base3;
    RESETN = 1'b0;
    iready = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check_reset_state("reset0");
    RESETN = 1'b1;
    @(posedge CLK); #1;

    // Single clean frame on ch2, plus first-word latency.
    clr_counts();
    push(2, hw(8'h20)); push(2, dw(8'h21)); push(2, dw(8'h22)); push(2, fw(8'h23));
    expect_w(hw(8'h20), -1); expect_w(dw(8'h21), 1); expect_w(dw(8'h22), 1); expect_w(fw(8'h23), 1);
    @(posedge CLK); #1;
    chk("t1_busy", 64'(busy), 64'(1));
    chk("t1_grant", 64'(grant), 64'(2));
    chk("t1_vld_early", 64'(ovalid), 64'(0));
    @(posedge CLK); #1;
    chk("t1_vld_first", 64'(ovalid), 64'(1));
    drain("t1");
    check_errs("t1", 0, 0, 0);
    chk("t1_re2_cycles", 64'(re_cnt[2]), 64'(4));

    // Round robin across all channels after a fresh reset.
    RESETN = 1'b0;
    @(posedge CLK); #1;
    check_reset_state("reset1");
    RESETN = 1'b1;
    clr_counts();
    for (int k = 0; k < 4; k++) begin
      push(k, hw(8'(8'h10 + k)));
      push(k, fw(8'(8'h10 + k)));
    end
    push(0, hw(8'h18)); push(0, fw(8'h18));
    expect_w(hw(8'h10), -1); expect_w(fw(8'h10), 1);
    expect_w(hw(8'h11), 2);  expect_w(fw(8'h11), 1);
    expect_w(hw(8'h12), 2);  expect_w(fw(8'h12), 1);
    expect_w(hw(8'h13), 2);  expect_w(fw(8'h13), 1);
    expect_w(hw(8'h18), 2);  expect_w(fw(8'h18), 1);
    drain("t2");
    check_errs("t2", 0, 0, 0);

    // Lost header on ch1.
    clr_counts();
    push(1, dw(8'h31)); push(1, dw(8'h32)); push(1, fw(8'h33));
    expect_w(SH, -1); expect_w(dw(8'h31), 1); expect_w(dw(8'h32), 1); expect_w(fw(8'h33), 1);
    drain("t3");
    check_errs("t3", 1, 0, 0);

    // Lost footer on ch0: the second header reopens a new frame.
    clr_counts();
    push(0, hw(8'h40)); push(0, dw(8'h41)); push(0, hw(8'h42)); push(0, dw(8'h43)); push(0, fw(8'h44));
    expect_w(hw(8'h40), -1); expect_w(dw(8'h41), 1); expect_w(SF, 1);
    expect_w(hw(8'h42), 2);  expect_w(dw(8'h43), 1); expect_w(fw(8'h44), 1);
    drain("t4");
    check_errs("t4", 0, 1, 0);

    // Overlong frame on ch3 with a 4-word limit.
    clr_counts();
    push(3, hw(8'h50));
    for (int i = 1; i <= 6; i++) push(3, dw(8'(8'h50 + i)));
    push(3, fw(8'h57));
    expect_w(hw(8'h50), -1); expect_w(dw(8'h51), 1); expect_w(dw(8'h52), 1); expect_w(SF, 1);
    expect_w(SH, 2); expect_w(dw(8'h53), 1); expect_w(dw(8'h54), 1); expect_w(SF, 1);
    expect_w(SH, 2); expect_w(dw(8'h55), 1); expect_w(dw(8'h56), 1); expect_w(fw(8'h57), 1);
    drain("t5");
    check_errs("t5", 2, 0, 2);

    // Random backpressure on two channels.
    clr_counts();
    push(1, hw(8'h60)); push(1, dw(8'h61)); push(1, dw(8'h62)); push(1, fw(8'h63));
    push(2, hw(8'h70)); push(2, dw(8'h71)); push(2, fw(8'h72));
    expect_w(hw(8'h60), -1); expect_w(dw(8'h61), -1); expect_w(dw(8'h62), -1); expect_w(fw(8'h63), -1);
    expect_w(hw(8'h70), -1); expect_w(dw(8'h71), -1); expect_w(fw(8'h72), -1);
    rnd = 1'b1;
    drain("t6");
    rnd = 1'b0;
    iready = 1'b1;
    @(posedge CLK); #1;
    chk("t6_pops_ch1", 64'(re_cnt[1]), 64'(4));
    chk("t6_pops_ch2", 64'(re_cnt[2]), 64'(3));
    for (int k = 0; k < 4; k++) chk("t6_fifo_empty", 64'(rp[k]), 64'(wp[k]));
    check_errs("t6", 0, 0, 0);

    // Reset in the middle of a ch3 frame.
    clr_counts();
    base3 = rp[3];
    push(3, hw(8'h80)); push(3, dw(8'h81)); push(3, dw(8'h82)); push(3, fw(8'h83));
    expect_w(hw(8'h80), -1);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    iready = 1'b0;
    RESETN = 1'b0;
    @(posedge CLK); #1;
    check_reset_state("reset2");
    chk("t7_fifo_pops", 64'(rp[3] - base3), 64'(2));
    chk("t7_sb_empty", 64'(exp_q.size()), 64'(0));
    RESETN = 1'b1;
    iready = 1'b1;
    push(0, hw(8'h90)); push(0, fw(8'h90));
    expect_w(hw(8'h90), -1); expect_w(fw(8'h90), 1);
    expect_w(SH, 2); expect_w(dw(8'h82), 1); expect_w(fw(8'h83), 1);
    drain("t7");
    check_errs("t7", 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
